keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, is the number of cp cycles per scan tick (legal range >= 4).
REQ-002 Parameter DEB_SCANS, default 4, is the number of consecutive agreeing ticks needed to accept a press or a release (legal range 1..15).
REQ-003 Parameter REPEAT_SCANS, default 50, is the number of ticks between auto-repeat pulses (legal range >= 1).
REQ-004 Port cp  in  1  is the single clock; every register is clocked on its rising edge.
REQ-005 Port rst  in  1  is the reset, synchronous and active-high.
REQ-006 Port rows  out  4  drives the keypad rows, active-low, with exactly one bit low at any time.
REQ-007 Port cols  in  4  reads the keypad columns, active-low and asynchronous to cp.
REQ-008 Port key  out  4  carries the accepted key code, equal to row*4+col.
REQ-009 Port key_valid  out  1  is a one-cycle pulse per accepted press (and per repeat, when compiled in).
REQ-010 Port key_held  out  1  is a level that is high from press acceptance until release acceptance.

Function
REQ-011 cols SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-012 A tick SHALL pulse for one cycle every SCAN_DIV cycles, from a free-running counter of $clog2(SCAN_DIV) bits that wraps at SCAN_DIV-1.
REQ-013 The FSM SHALL have exactly four states, SCAN, DEBOUNCE, HELD and RELEASE, and SHALL act only on tick cycles.
REQ-014 SCAN: if any synced column is low, SHALL capture the row and the lowest-index low column, set cnt=1 and go to DEBOUNCE; otherwise SHALL rotate rows by one (row 3 wraps to row 0).
REQ-015 DEBOUNCE: rows SHALL stay frozen; if the captured column is still low, cnt++; if it is high, SHALL go to SCAN and advance the row.
REQ-016 DEBOUNCE acceptance: when cnt reaches DEB_SCANS, SHALL load key, pulse key_valid, set key_held and go to HELD; with DEB_SCANS=1 this happens on the first confirming tick.
REQ-017 HELD: if the captured column is high, SHALL set cnt=1 and go to RELEASE; otherwise SHALL stay in HELD.
REQ-018 RELEASE: if the column is low again, SHALL return to HELD with no new key_valid; if high, cnt++, and at DEB_SCANS SHALL clear key_held, go to SCAN and advance the row.
REQ-019 Latency: key_valid SHALL assert in the cycle after the accepting tick; key SHALL be stable from that cycle until the next acceptance.
REQ-020 Keys pressed simultaneously in other rows SHALL be ignored while the row is frozen; in the frozen row, the lowest column wins.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 While rst is high: rows=4'b1110, key=0, key_valid=0, key_held=0, state=SCAN, counters=0, synchronizer flops=4'b1111.
REQ-023 rst asserted mid-debounce or mid-hold SHALL abandon the key with no key_valid pulse; scanning SHALL restart at row 0.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN compiled in: while in HELD, key_valid SHALL re-pulse with the same key every REPEAT_SCANS ticks after acceptance; the repeat counter SHALL clear on entry to HELD and SHALL not advance during RELEASE.
REQ-025 Macro KEYPAD_REPEAT_EN absent: exactly one key_valid per press, and no repeat counter logic is present.

Structure
REQ-026 Package keypad_pkg SHALL hold the FSM state enum, the row-reset constant 4'b1110 and the key-code width constant (4).
REQ-027 The tick divider SHALL be a sub-module named scan_tick, parameterized by SCAN_DIV, with ports cp, rst and tick.

Verification (SCAN_DIV=8, DEB_SCANS=3, REPEAT_SCANS=4)
REQ-028 No key pressed: rows cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per 8 cycles; key_valid stays 0.
REQ-029 Hold the row-2 / col-1 key steady: exactly one key_valid pulse, key=4'h9, key_held=1, accepted on the 3rd tick after capture.
REQ-030 Bounce of 1-tick press, 1-tick release, then steady press on row-0 / col-3: no pulse on the bounce, one pulse on the steady press, key=4'h3.
REQ-031 Press on row-1 with cols 1 and 2 both low: key=4'h5; a simultaneous row-3 key is ignored until release completes.
REQ-032 Assert rst while key_held=1: outputs return to reset values on the next edge; no spurious key_valid when rst falls with the key still pressed before DEB_SCANS fresh ticks.
REQ-033 With KEYPAD_REPEAT_EN defined, hold the key for 12 ticks after acceptance: pulses at acceptance and at +4, +8 and +12 ticks; without the macro, one pulse only.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   state_t     - scanner FSM state encoding
//   ROWS_RST    - row drive pattern after reset (row 0 active, active-low)
//   KEY_W       - width of the key code (row*4 + col)
//   lowest_low  - index of the lowest-numbered low bit in a 4-bit active-low vector
//   row_index   - index of the single low bit in the row drive pattern
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROWS_RST = 4'b1110;
    localparam int         KEY_W    = 4;

    function automatic logic [1:0] lowest_low(input logic [3:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!vec[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] vec);
        return lowest_low(vec);
    endfunction

endpackage

// File: rtl/scan_tick.sv
// scan_tick
// Free-running scan divider. Produces a one-cycle tick every SCAN_DIV cycles.
// Ports:
//   cp   in  - clock
//   rst  in  - synchronous active-high reset (counter to 0)
//   tick out - high for one cycle when the counter sits at SCAN_DIV-1
module scan_tick #(
    parameter int SCAN_DIV = 100000
) (
    input  logic cp,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge cp) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(SCAN_DIV - 1));

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// 4x4 matrix keypad scanner with debounce on both press and release.
// Ports:
//   cp        in  - clock
//   rst       in  - synchronous active-high reset
//   rows      out - row drive, active-low, exactly one row low
//   cols      in  - column sense, active-low, asynchronous to cp
//   key       out - accepted key code (row*4 + col)
//   key_valid out - one-cycle pulse per accepted press (and per repeat)
//   key_held  out - high from press acceptance until release acceptance
// Build option: define KEYPAD_REPEAT_EN to re-pulse key_valid every
// REPEAT_SCANS ticks while a key stays held.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotating rows one per tick, looking for any low column
// DEBOUNCE | row frozen, counting ticks the captured column stays low
// HELD     | key accepted, waiting for the captured column to go high
// RELEASE  | row frozen, counting ticks the captured column stays high
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEB_SCANS    = 4,
    parameter int REPEAT_SCANS = 50
) (
    input  logic             cp,
    input  logic             rst,
    output logic [3:0]       rows,
    input  logic [3:0]       cols,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_held
);

    logic       tick;
    logic [3:0] cols_m;
    logic [3:0] cols_s;
    state_t     state;
    logic [1:0] col_sel;
    logic [3:0] cnt;
    logic       col_up;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS) + 1;
    logic [RW-1:0] rep_cnt;
`else
    // Keeps the parameter referenced in builds without auto-repeat.
    logic unused_repeat;
    assign unused_repeat = (REPEAT_SCANS > 0);
`endif

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .cp   (cp),
        .rst  (rst),
        .tick (tick)
    );

    // Rows stay frozen outside SCAN, so this always refers to the captured key.
    assign col_up = cols_s[col_sel];

    always_ff @(posedge cp) begin
        if (rst) begin
            cols_m    <= 4'b1111;
            cols_s    <= 4'b1111;
            rows      <= ROWS_RST;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            state     <= SCAN;
            col_sel   <= 2'd0;
            cnt       <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            cols_m    <= cols;
            cols_s    <= cols_m;
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (cols_s != 4'b1111) begin
                            col_sel <= lowest_low(cols_s);
                            cnt     <= 4'd1;
                            state   <= DEBOUNCE;
                        end else begin
                            rows <= {rows[2:0], rows[3]};
                        end
                    end
                    DEBOUNCE: begin
                        if (!col_up) begin
                            // cnt already includes the capture tick, so acceptance
                            // lands DEB_SCANS ticks after capture.
                            if (cnt >= 4'(DEB_SCANS)) begin
                                key       <= {row_index(rows), col_sel};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= '0;
`endif
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= SCAN;
                            rows  <= {rows[2:0], rows[3]};
                        end
                    end
                    HELD: begin
                        if (col_up) begin
                            cnt   <= 4'd1;
                            state <= RELEASE;
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rep_cnt == RW'(REPEAT_SCANS - 1)) begin
                            rep_cnt   <= '0;
                            key_valid <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
`endif
                    end
                    RELEASE: begin
                        if (!col_up) begin
                            state <= HELD;
                        end else if (cnt >= 4'(DEB_SCANS)) begin
                            key_held <= 1'b0;
                            state    <= SCAN;
                            rows     <= {rows[2:0], rows[3]};
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule
